// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters with DLY-deep registered sync/video/strobe outputs
// Optional macro VGA_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen #(
  parameter int H_DISP = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_DISP = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0,
  parameter int DLY    = 1,
  parameter int CW     = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_DISP);
  localparam logic [CW-1:0] V_VIS  = CW'(V_DISP);
  localparam logic [CW-1:0] HS_BEG = CW'(H_DISP + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(V_DISP + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_DISP + V_FP + V_SYNC - 1);

  // Pipeline word: {hsync, vsync, video_on, line_start, frame_start}
  localparam logic [4:0] IDLE = {!H_POL, !V_POL, 3'b000};

  logic [CW-1:0] r_h;
  logic [CW-1:0] r_v;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_hs_act;
  logic          w_vs_act;
  logic [4:0]    w_raw;
  logic [4:0]    r_pipe [DLY];

  assign w_h_wrap = (r_h == H_LAST);
  assign w_v_wrap = (r_v == V_LAST);
  assign w_hs_act = (r_h >= HS_BEG) && (r_h <= HS_END);
  assign w_vs_act = (r_v >= VS_BEG) && (r_v <= VS_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (!en) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_wrap) begin
      r_h <= '0;
      r_v <= w_v_wrap ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  // Disabled cycles feed inactive values so the chain drains cleanly.
  always_comb begin
    w_raw = IDLE;
    if (en) begin
      w_raw = {w_hs_act ? H_POL : !H_POL,
               w_vs_act ? V_POL : !V_POL,
               (r_h < H_VIS) && (r_v < V_VIS),
               (r_h == '0),
               (r_h == '0) && (r_v == '0)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DLY; i++) r_pipe[i] <= IDLE;
    end else begin
      r_pipe[0] <= w_raw;
      for (int i = 1; i < DLY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign pixel_x = r_h;
  assign pixel_y = r_v;
  assign {hsync, vsync, video_on, line_start, frame_start} = r_pipe[DLY-1];

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (en && w_h_wrap && w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen against a raster-position model
// With VGA_FRAME_CNT_EN defined, polarities are active-high and frame_cnt is checked.
module tb_vga_timing_gen;

  localparam int H_DISP = 16, H_FP = 4, H_SYNC = 6, H_BP = 4;
  localparam int V_DISP = 10, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int HT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int VT = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;
  localparam int DLY = 2;
  localparam int CW = 12;
`ifdef VGA_FRAME_CNT_EN
  localparam bit HP = 1'b1;
  localparam bit VP = 1'b1;
`else
  localparam bit HP = 1'b0;
  localparam bit VP = 1'b0;
`endif
  localparam logic [4:0] IDLE = {~HP, ~VP, 3'b000};

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [CW-1:0] pixel_x, pixel_y;
  logic hsync, vsync, video_on, line_start, frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  vga_timing_gen #(
    .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL(HP), .V_POL(VP), .DLY(DLY), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int p = 0;
  int fcnt = 0;
  int cyc = 0;
  logic [4:0] q[$];
  logic [4:0] exp_o;
  int exp_x, exp_y;

  // Outputs as a function of raster position p = v*HT + h.
  function automatic logic [4:0] raw_of(int pos, logic e);
    int h, v;
    h = pos % HT;
    v = pos / HT;
    if (!e) return IDLE;
    return {(h >= H_DISP + H_FP && h < H_DISP + H_FP + H_SYNC) ? HP : ~HP,
            (v >= V_DISP + V_FP && v < V_DISP + V_FP + V_SYNC) ? VP : ~VP,
            (h < H_DISP && v < V_DISP),
            (h == 0),
            (pos == 0)};
  endfunction

  function automatic logic [4:0] obs_o();
    return {hsync, vsync, video_on, line_start, frame_start};
  endfunction

  task automatic model_reset();
    p = 0;
    fcnt = 0;
    q.delete();
    for (int i = 0; i < DLY; i++) q.push_back(IDLE);
    exp_o = IDLE;
    exp_x = 0;
    exp_y = 0;
  endtask

  // Advance one clock; model updates at posedge, expectations valid at negedge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      q.push_back(raw_of(p, en));
      void'(q.pop_front());
      if (en && p == FRAME - 1) fcnt++;
      p = en ? (p + 1) % FRAME : 0;
    end
    exp_o = q[0];
    exp_x = p % HT;
    exp_y = p / HT;
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    model_reset();
    #2;
    step();
    step();
    checks++;
    if (obs_o() !== IDLE) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", obs_o(), IDLE);
    end
    checks++;
    if (pixel_x !== '0 || pixel_y !== '0) begin
      errors++;
      $display("FAIL reset_pixel: got (%0d,%0d) want (0,0)", pixel_x, pixel_y);
    end
    rst_n = 1'b1;
    en = 1'b1;
  endtask

  task automatic test_free_run();
    int px_cyc = -1, hs_first = -1, hs_run = 0, hs_w = -1;
    int vs_run = 0, vs_w = -1, fs_last = -1, fs_per = -1;
    logic hs_prev = 1'b0, vs_prev = 1'b0;
    for (int i = 0; i < 2 * FRAME + 60; i++) begin
      step();
      checks++;
      if (obs_o() !== exp_o || pixel_x !== CW'(exp_x) || pixel_y !== CW'(exp_y)) begin
        errors++;
        $display("FAIL free_run cyc %0d: out=%b x=%0d y=%0d want out=%b x=%0d y=%0d",
                 cyc, obs_o(), pixel_x, pixel_y, exp_o, exp_x, exp_y);
      end
      if (px_cyc < 0 && pixel_x == CW'(H_DISP + H_FP)) px_cyc = cyc;
      if (hsync == HP) begin
        if (!hs_prev && hs_first < 0 && px_cyc >= 0) hs_first = cyc;
        hs_run++;
      end else if (hs_prev && hs_w < 0) hs_w = hs_run;
      else hs_run = 0;
      hs_prev = (hsync == HP);
      if (vsync == VP) vs_run++;
      else if (vs_prev && vs_w < 0) vs_w = vs_run;
      vs_prev = (vsync == VP);
      if (frame_start) begin
        if (fs_last >= 0 && fs_per < 0) fs_per = cyc - fs_last;
        fs_last = cyc;
      end
    end
    checks++;
    if (hs_w != H_SYNC) begin
      errors++;
      $display("FAIL hsync_width: got %0d want %0d", hs_w, H_SYNC);
    end
    checks++;
    if (hs_first - px_cyc != DLY) begin
      errors++;
      $display("FAIL hsync_latency: got %0d want %0d", hs_first - px_cyc, DLY);
    end
    checks++;
    if (vs_w != V_SYNC * HT) begin
      errors++;
      $display("FAIL vsync_width: got %0d want %0d", vs_w, V_SYNC * HT);
    end
    checks++;
    if (fs_per != FRAME) begin
      errors++;
      $display("FAIL frame_period: got %0d want %0d", fs_per, FRAME);
    end
  endtask

  task automatic test_en_hold();
    int n = 0;
    while (!(exp_x == 10 && exp_y == 5) && n < 2 * FRAME) begin
      step();
      n++;
    end
    en = 1'b0;
    step();
    checks++;
    if (pixel_x !== '0 || pixel_y !== '0) begin
      errors++;
      $display("FAIL en_hold_pixel: got (%0d,%0d) want (0,0)", pixel_x, pixel_y);
    end
    step();
    checks++;
    if (obs_o() !== IDLE) begin
      errors++;
      $display("FAIL en_hold_outputs: got %b want %b", obs_o(), IDLE);
    end
    step();
    en = 1'b1;
    step();
    step();
    checks++;
    if (frame_start !== 1'b1 || line_start !== 1'b1) begin
      errors++;
      $display("FAIL en_restart_fs: got fs=%b ls=%b want 1 1", frame_start, line_start);
    end
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) en = ~en;
      step();
      checks++;
      if (obs_o() !== exp_o || pixel_x !== CW'(exp_x) || pixel_y !== CW'(exp_y)) begin
        errors++;
        $display("FAIL random_en cyc %0d: out=%b x=%0d y=%0d want out=%b x=%0d y=%0d",
                 cyc, obs_o(), pixel_x, pixel_y, exp_o, exp_x, exp_y);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (!(exp_o[2] && exp_x > 3) && n < 2 * FRAME) begin
      step();
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (video_on !== 1'b0 || hsync !== ~HP || vsync !== ~VP || pixel_x !== '0 || pixel_y !== '0) begin
      errors++;
      $display("FAIL reset_mid: vo=%b hs=%b vs=%b x=%0d y=%0d want vo=0 hs=%b vs=%b (0,0)",
               video_on, hsync, vsync, pixel_x, pixel_y, ~HP, ~VP);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < FRAME + 20; i++) begin
      step();
      checks++;
      if (obs_o() !== exp_o || pixel_x !== CW'(exp_x) || pixel_y !== CW'(exp_y)) begin
        errors++;
        $display("FAIL after_reset cyc %0d: out=%b x=%0d y=%0d want out=%b x=%0d y=%0d",
                 cyc, obs_o(), pixel_x, pixel_y, exp_o, exp_x, exp_y);
      end
    end
  endtask

  task automatic test_frame_cnt();
`ifdef VGA_FRAME_CNT_EN
    for (int i = 0; i < FRAME + 5; i++) step();
    checks++;
    if (frame_cnt !== 16'(fcnt) || fcnt == 0) begin
      errors++;
      $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, fcnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_en_hold();
    test_random_en();
    test_reset_mid();
    test_frame_cnt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
